// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types, constants and jump-target helper for the instruction fetch unit
package ifetch_pkg;
  localparam int XLEN = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;
  function automatic logic is_jump(input logic [XLEN-1:0] insn);
    return insn[31:26] == OP_J || insn[31:26] == OP_JAL;
  endfunction
  // Region bits come from the address after the jump, as in MIPS J/JAL.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] insn);
    logic [XLEN-1:0] pc4;
    pc4 = pc + XLEN'(INSN_BYTES);
    return {pc4[31:28], insn[25:0], 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: fetch buses -- imem request/grant/response, decoder IR valid/ready, execute redirect
// master = fetch unit side, slave = environment (imem, decoder, execute) side.
interface ifetch_if;
  import ifetch_pkg::*;
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic ir_valid;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] ir_pc;
  logic ir_ready;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, ir_valid, ir, ir_pc,
    input imem_gnt, imem_rvalid, imem_rdata, ir_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input imem_req, imem_addr, ir_valid, ir, ir_pc,
    output imem_gnt, imem_rvalid, imem_rdata, ir_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: registered FIFO of {pc, insn} fetch entries
// Ports: clk, rst (async, active-high); i_push/i_data write; i_pop advances head;
// i_flush empties (wins over push/pop); o_data is the head entry; o_count the fill level.
module ifetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic [CW-1:0] o_count
);
  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign w_pop = i_pop && r_count != '0;
  assign w_push = i_push && (r_count != CW'(DEPTH) || w_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      if (w_push) r_wr <= inc(r_wr);
      if (w_pop) r_rd <= inc(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end -- PC, in-order imem reads, IR buffer, redirect squash
// Ports: clk, rst (async, active-high); bus (ifetch_if.master): imem_req/addr/gnt/rvalid/rdata,
// ir_valid/ir/ir_pc/ir_ready to the decoder, redirect_valid/redirect_pc from execute.
// Optional: define IFETCH_PREDECODE_JUMP_EN to self-redirect on buffered J/JAL words.
module ifetch_unit import ifetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic rst,
  ifetch_if.master bus
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [XLEN-1:0] r_pc;
  logic [OW-1:0] r_out, r_drop, w_out_nxt;
  logic [XLEN-1:0] r_pcq [MAX_OUTSTANDING];
  logic [QW-1:0] r_qhd, r_qtl;
  logic [CW-1:0] w_count;
  logic w_grant, w_live, w_push, w_pop, w_redir, w_jmp;
  logic [XLEN-1:0] w_rsp_pc, w_tgt;
  fetch_entry_t w_entry, w_head;
  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return p == QW'(MAX_OUTSTANDING - 1) ? '0 : p + QW'(1);
  endfunction
  assign w_rsp_pc = r_pcq[r_qhd];
  assign w_live = bus.imem_rvalid && r_drop == '0;
`ifdef IFETCH_PREDECODE_JUMP_EN
  assign w_jmp = w_live && is_jump(bus.imem_rdata);
`else
  assign w_jmp = 1'b0;
`endif
  assign w_redir = bus.redirect_valid || w_jmp;
  assign w_tgt = bus.redirect_valid ? bus.redirect_pc & ~XLEN'(3) : jump_target(w_rsp_pc, bus.imem_rdata);
  assign w_pop = bus.ir_valid && bus.ir_ready;
  // A self-redirecting jump word is still pushed; only an external redirect discards it.
  assign w_push = w_live && !bus.redirect_valid;
  assign w_entry = '{pc: w_rsp_pc, insn: bus.imem_rdata};
  // Issue only if every live in-flight word plus this one has a slot; the entry
  // the decoder drains this cycle counts as free so zero-wait memory streams 1/cycle.
  assign bus.imem_req = !rst && !w_redir && 32'(r_out) < 32'(MAX_OUTSTANDING)
    && 32'(BUF_DEPTH) - 32'(w_count) + 32'(w_pop) > 32'(r_out - r_drop);
  assign w_grant = bus.imem_req && bus.imem_gnt;
  assign w_out_nxt = r_out + OW'(w_grant) - OW'(bus.imem_rvalid);
  assign bus.imem_addr = r_pc;
  assign bus.ir_valid = w_count != '0;
  assign bus.ir = w_head.insn;
  assign bus.ir_pc = w_head.pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc <= RESET_PC;
      r_out <= '0;
      r_drop <= '0;
      r_qhd <= '0;
      r_qtl <= '0;
    end else begin
      r_pc <= w_redir ? w_tgt : w_grant ? r_pc + XLEN'(INSN_BYTES) : r_pc;
      r_out <= w_out_nxt;
      r_drop <= w_redir ? w_out_nxt : (bus.imem_rvalid && r_drop != '0) ? r_drop - OW'(1) : r_drop;
      if (w_grant) r_qtl <= qinc(r_qtl);
      if (bus.imem_rvalid) r_qhd <= qinc(r_qhd);
    end
  always_ff @(posedge clk)
    if (w_grant) r_pcq[r_qtl] <= r_pc;
  ifetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_flush(bus.redirect_valid),
    .i_data(w_entry),
    .o_data(w_head),
    .o_count(w_count)
  );
  a_rvalid_orphan: assert property (@(posedge clk) disable iff (rst) !(bus.imem_rvalid && r_out == '0));
endmodule
